// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and data.
// Define ARB_TIMEOUT_EN to abort accesses that see no mem_done within TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        busy,
  output logic        err
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FETCH
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] starve;
  logic          if_ok;
  logic          dm_ok;
  logic          pick_dm;
  logic          pick_if;
  logic          fin;
  logic          tmo;

  // a requester's req is ignored while its own done pulse is high
  assign if_ok   = if_req & ~if_done;
  assign dm_ok   = dm_req & ~dm_done;
  assign pick_dm = (state == IDLE) & dm_ok
                 & ~(if_ok & (starve == SW'(MAX_STARVE)));
  assign pick_if = (state == IDLE) & if_ok & ~pick_dm;
  assign fin     = (state != IDLE) & (mem_done | tmo);

  assign busy     = (state != IDLE);
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + TW'(1);
  end

  assign tmo = (state != IDLE) & ~mem_done
             & (wait_cnt == TW'(TIMEOUT - 1));
`else
  // no watchdog: wait for mem_done forever
  assign tmo = 1'b0 & (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (pick_dm && !dm_addr[0])      state_nx = DATA;
        else if (pick_if && !if_addr[0]) state_nx = FETCH;
      end
      DATA, FETCH: begin
        if (fin) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve    <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (state == IDLE) begin
        if (!if_req || pick_if)
          starve <= '0;
        else if (pick_dm && starve != SW'(MAX_STARVE))
          starve <= starve + SW'(1);
      end
      // unaligned winners never reach memory
      if (pick_dm) begin
        if (dm_addr[0]) begin
          err      <= 1'b1;
          dm_done  <= 1'b1;
          dm_rdata <= '0;
        end else begin
          mem_en    <= 1'b1;
          mem_wr    <= dm_wr;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
        end
      end else if (pick_if) begin
        if (if_addr[0]) begin
          err      <= 1'b1;
          if_done  <= 1'b1;
          if_rdata <= '0;
        end else begin
          mem_en    <= 1'b1;
          mem_wr    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
        end
      end
      if (fin) begin
        mem_en <= 1'b0;
        mem_wr <= 1'b0;
        if (tmo) err <= 1'b1;
        if (state == DATA) begin
          dm_done  <= 1'b1;
          dm_rdata <= (tmo || mem_wr) ? '0 : mem_rdata;
        end else begin
          if_done  <= 1'b1;
          if_rdata <= tmo ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters and memory against a transaction model,
// plus directed load/store/unaligned/reset (and watchdog) scenarios.
module tb_mem_port_arbiter;

  localparam int MS = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        busy;
  logic        err;

  mem_port_arbiter #(.MAX_STARVE(MS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;
  bit rnd_on = 0;
  int fix_lat = 0;

  // model: who owns memory (0 nobody, 1 data, 2 fetch) and the access it carries
  logic [15:0] ram [32];
  int          who;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  int          starve;
  int          lat_left;
  int          waited;
  logic        e_if_done;
  logic        e_dm_done;
  logic        e_err;
  logic [15:0] e_if_rdata;
  logic [15:0] e_dm_rdata;

  task automatic chk1(string n, logic a, logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b @%0t", n, a, e, $time);
    end
  endtask

  task automatic chk16(string n, logic [15:0] a, logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", n, a, e, $time);
    end
  endtask

  task automatic start(int w, logic wr, logic [15:0] a, logic [15:0] d);
    if (a[0]) begin
      e_err = 1'b1;
      if (w == 1) begin e_dm_done = 1'b1; e_dm_rdata = '0; end
      else        begin e_if_done = 1'b1; e_if_rdata = '0; end
    end else begin
      who      = w;
      m_wr     = wr;
      m_addr   = a;
      m_wdata  = d;
      waited   = 0;
      lat_left = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
    end
  endtask

  task automatic model_step();
    logic ifp, dmp, gd, gf;
    if (rst) begin
      who = 0; starve = 0; e_err = 1'b0;
      e_if_done = 1'b0; e_dm_done = 1'b0;
      e_if_rdata = '0; e_dm_rdata = '0;
      return;
    end
    ifp = if_req && !e_if_done;
    dmp = dm_req && !e_dm_done;
    e_if_done = 1'b0;
    e_dm_done = 1'b0;
    if (who == 0) begin
      gd = dmp && !(ifp && starve == MS);
      gf = ifp && !gd;
      if (!if_req || gf)        starve = 0;
      else if (gd && starve < MS) starve++;
      if (gd)      start(1, dm_wr, dm_addr, dm_wdata);
      else if (gf) start(2, 1'b0, if_addr, 16'h0000);
    end else if (mem_done) begin
      if (who == 1) begin
        e_dm_done  = 1'b1;
        e_dm_rdata = m_wr ? 16'h0000 : ram[m_addr[5:1]];
        if (m_wr) ram[m_addr[5:1]] = m_wdata;
      end else begin
        e_if_done  = 1'b1;
        e_if_rdata = ram[m_addr[5:1]];
      end
      who = 0;
    end
`ifdef ARB_TIMEOUT_EN
    else begin
      waited++;
      if (waited == TO) begin
        e_err = 1'b1;
        if (who == 1) begin e_dm_done = 1'b1; e_dm_rdata = '0; end
        else          begin e_if_done = 1'b1; e_if_rdata = '0; end
        who = 0;
      end
    end
`endif
  endtask

  task automatic compare();
    chk1("mem_en", mem_en, who != 0);
    chk1("busy", busy, who != 0);
    chk1("err", err, e_err);
    chk1("if_done", if_done, e_if_done);
    chk1("dm_done", dm_done, e_dm_done);
    chk1("if_stall", if_stall, if_req & ~e_if_done);
    chk1("dm_stall", dm_stall, dm_req & ~e_dm_done);
    if (who != 0) begin
      chk1("mem_wr", mem_wr, m_wr);
      chk16("mem_addr", mem_addr, m_addr);
      if (m_wr) chk16("mem_wdata", mem_wdata, m_wdata);
    end
    if (e_if_done) chk16("if_rdata", if_rdata, e_if_rdata);
    if (e_dm_done) chk16("dm_rdata", dm_rdata, e_dm_rdata);
  endtask

  always @(negedge clk) if (chk_on) compare();

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 63));
    if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
    return a;
  endfunction

  task automatic drive_mem();
    if (who != 0) begin
      mem_done  = (lat_left == 0);
      mem_rdata = ram[m_addr[5:1]];
      if (lat_left > 0) lat_left--;
    end else begin
      mem_done  = rnd_on && ($urandom_range(0, 9) == 0);
      mem_rdata = 16'($urandom);
    end
  endtask

  task automatic drive_req();
    if (rst) rst = ($urandom_range(0, 1) == 0);
    else     rst = ($urandom_range(0, 199) == 0);
    if (rst) begin
      if_req = 1'b0;
      dm_req = 1'b0;
      return;
    end
    if (!if_req || e_if_done) begin
      if_req  = ($urandom_range(0, 2) == 0);
      if_addr = rand_addr();
    end
    if (!dm_req || e_dm_done) begin
      dm_req   = ($urandom_range(0, 2) == 0);
      dm_wr    = ($urandom_range(0, 1) == 1);
      dm_addr  = rand_addr();
      dm_wdata = 16'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    drive_mem();
    if (rnd_on) drive_req();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_done = 1'b0; mem_rdata = '0;
    tick();
    chk_on = 1;
    tick();
    chk1("rst mem_en", mem_en, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst err", err, 1'b0);
    chk16("rst mem_addr", mem_addr, 16'h0000);
    chk16("rst dm_rdata", dm_rdata, 16'h0000);
    rst = 1'b0;
    tick();

    // single load, memory answers on the second mem_en cycle
    fix_lat = 1;
    ram[8] = 16'hBEEF;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    tick();
    chk1("ld en", mem_en, 1'b1);
    chk16("ld addr", mem_addr, 16'h0010);
    chk1("ld wr", mem_wr, 1'b0);
    chk1("ld stall", dm_stall, 1'b1);
    tick();
    chk1("ld en2", mem_en, 1'b1);
    tick();
    chk1("ld done", dm_done, 1'b1);
    chk16("ld data", dm_rdata, 16'hBEEF);
    chk1("ld stall2", dm_stall, 1'b0);
    dm_req = 1'b0;
    tick();
    chk1("ld done1", dm_done, 1'b0);

    // simultaneous store + fetch; fetch takes the store's done cycle
    fix_lat = 0;
    ram[0] = 16'hA5A5;
    if_req = 1'b1; if_addr = 16'h0000;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0020; dm_wdata = 16'h1234;
    tick();
    chk1("st en", mem_en, 1'b1);
    chk1("st wr", mem_wr, 1'b1);
    chk16("st addr", mem_addr, 16'h0020);
    chk16("st wdata", mem_wdata, 16'h1234);
    chk1("st if_stall", if_stall, 1'b1);
    tick();
    chk1("st done", dm_done, 1'b1);
    chk1("st en_off", mem_en, 1'b0);
    tick();
    dm_req = 1'b0;
    chk1("fe en", mem_en, 1'b1);
    chk1("fe wr", mem_wr, 1'b0);
    chk16("fe addr", mem_addr, 16'h0000);
    tick();
    chk1("fe done", if_done, 1'b1);
    chk16("fe data", if_rdata, 16'hA5A5);
    if_req = 1'b0;
    tick();
    chk1("no 2nd store", mem_en, 1'b0);

    // unaligned data access, then both unaligned together
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0013;
    tick();
    chk1("ua done", dm_done, 1'b1);
    chk16("ua data", dm_rdata, 16'h0000);
    chk1("ua err", err, 1'b1);
    chk1("ua en", mem_en, 1'b0);
    if_req = 1'b1; if_addr = 16'h0003;
    dm_addr = 16'h0015;
    tick();
    chk1("ua2 dm", dm_done, 1'b0);
    tick();
    chk1("ua2 dm1", dm_done, 1'b1);
    chk1("ua2 if1", if_done, 1'b0);
    dm_req = 1'b0;
    tick();
    chk1("ua2 if2", if_done, 1'b1);
    if_req = 1'b0;
    tick();
    chk1("ua err sticky", err, 1'b1);

    // reset for two cycles while a load is outstanding
    fix_lat = 1000;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0010;
    tick();
    chk1("rs en", mem_en, 1'b1);
    rst = 1'b1;
    dm_req = 1'b0;
    tick();
    chk1("rs en0", mem_en, 1'b0);
    chk1("rs busy", busy, 1'b0);
    chk1("rs err", err, 1'b0);
    chk1("rs dm_done", dm_done, 1'b0);
    tick();
    rst = 1'b0;
    mem_done = 1'b1;
    tick();
    chk1("rs late dm", dm_done, 1'b0);
    chk1("rs late if", if_done, 1'b0);
    chk1("rs late busy", busy, 1'b0);

`ifdef ARB_TIMEOUT_EN
    begin
      int cnt;
      cnt = 0;
      if_req = 1'b1; if_addr = 16'h0004;
      tick();
      for (int i = 0; i < 20 && mem_en; i++) begin
        cnt++;
        tick();
      end
      chk16("to cycles", 16'(cnt), 16'd8);
      chk1("to done", if_done, 1'b1);
      chk16("to data", if_rdata, 16'h0000);
      chk1("to err", err, 1'b1);
      if_req = 1'b0;
      mem_done = 1'b1;
      tick();
      chk1("to late", if_done, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end
`endif

    fix_lat = -1;
    rnd_on  = 1;
    repeat (3000) tick();
    rnd_on = 0;
    rst    = 1'b0;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences one shared, variable-latency, single-port memory between the fetch stage (read-only instruction requests) and the memory stage (data load/store).
- Sits between fetch/memory stages and the unified memory model. Replaces the two independent memory instances used in the single-cycle datapath.
- Produces per-requester stall signals for the pipeline controller, plus a sticky error.

Parameters:
- MAX_STARVE, 4: consecutive data grants allowed while fetch is pending before fetch is forced next.
- TIMEOUT, 64: cycles to wait for mem_done before abort; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request, level
- if_addr  in  16  fetch byte address
- if_rdata  out  16  instruction word, valid with if_done
- if_done  out  1  one-cycle completion pulse to fetch
- if_stall  out  1  if_req & ~if_done, combinational
- dm_req  in  1  data request, level
- dm_wr  in  1  1=store, 0=load
- dm_addr  in  16  data byte address
- dm_wdata  in  16  store data
- dm_rdata  out  16  load data, valid with dm_done
- dm_done  out  1  one-cycle completion pulse to memory stage
- dm_stall  out  1  dm_req & ~dm_done, combinational
- mem_en  out  1  memory request, held until mem_done
- mem_wr  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid with mem_done
- mem_done  in  1  memory completion, one-cycle pulse
- busy  out  1  state != IDLE
- err  out  1  sticky error flag

Behaviour:
- Reset: synchronous, active-high. State=IDLE; starve counter=0; mem_en, mem_wr, if_done, dm_done, err=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0.
- Reset mid-transaction drops the access. mem_en is low after the reset edge. A later mem_done is ignored in IDLE.
- FSM states: IDLE, DATA, FETCH.
- IDLE arbitration, sampled each cycle:
  - dm_req wins over if_req, except when starve counter == MAX_STARVE and if_req is high; then fetch wins.
  - The winner's address, wr and wdata are registered; next state is DATA or FETCH.
  - A fetch request registers wr=0.
- mem_en/mem_wr/mem_addr/mem_wdata come from registers. They are high/stable for every cycle of DATA/FETCH, starting the cycle after grant.
- Leaving DATA/FETCH: on mem_done, return to IDLE. On the following cycle:
  - pulse the owner's done for 1 cycle;
  - drive its rdata from registered mem_rdata;
  - store: dm_rdata=0.
- Timing: minimum request-to-done latency is 3 cycles with mem_done returned on the first mem_en cycle (req seen at cycle N, grant edge, mem_en at N+1, done at N+2).
- Requester protocol: hold req and operands stable until its done pulse. Requester may drop or re-raise req in the done cycle.
- Done-cycle rule: the arbiter ignores a requester's req in the cycle its done is asserted. No duplicate grant is issued; the other requester may be granted in that cycle.
- Starve counter:
  - increments on each data grant made while if_req is high (saturates at MAX_STARVE);
  - clears on any fetch grant;
  - clears when if_req is low in IDLE.
- Alignment check: a req with address bit 0 set is not sent to memory.
  - err is set (sticky until rst).
  - The requester's done pulses the next cycle with rdata=0; state stays IDLE.
- Simultaneous if_req & dm_req with both unaligned: data is handled first, fetch next cycle.
- mem_done while IDLE: ignored, no error.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - a cycle counter runs in DATA/FETCH, cleared on grant;
  - if TIMEOUT cycles pass without mem_done: drop mem_en, return to IDLE, set err, pulse owner's done next cycle with rdata=0;
  - a late mem_done is ignored.
- When undefined: no counter; the arbiter waits indefinitely for mem_done; TIMEOUT is unused.

Test Plan:
- Reset: hold rst 2 cycles during an active DATA access → mem_en=0, busy=0, err=0, all dones 0 after the edge; later mem_done causes no done pulse.
- Single load: dm_req=1, dm_wr=0, dm_addr=16'h0010; memory returns 16'hBEEF with 2-cycle latency → mem_addr=16'h0010, mem_wr=0; dm_done one cycle with dm_rdata=16'hBEEF; dm_stall high until then.
- Simultaneous requests: if_req (16'h0000) and dm_req store (16'h0020, wdata 16'h1234) in same cycle → store to 16'h0020 issued first; fetch issued in dm_done cycle; no second store.
- Starvation: if_req held, dm_req re-raised continuously, MAX_STARVE=4 → 4 data grants, then fetch grant, then data resumes.
- Unaligned: dm_addr=16'h0013 → mem_en never asserts; dm_done next cycle, dm_rdata=0; err=1 and stays 1 until rst.
- ARB_TIMEOUT_EN, TIMEOUT=8: fetch with no mem_done → mem_en drops after 8 cycles; if_done pulses with if_rdata=0; err=1.
